// File: rtl/ex_muldiv_unit_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_pkg
//  Shared definitions for the iterative RV32M multiply/divide unit:
//  datapath width, iteration counter width, funct3 op codes and the FSM
//  state encoding.
// ----------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

   localparam int MD_XLEN  = 32;
   localparam int MD_CNT_W = 6;

   // RV32M funct3 op codes
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

endpackage : ex_muldiv_unit_pkg

// File: rtl/ex_muldiv_unit_sign_fix.sv
// ----------------------------------------------------------------------------
// muldiv_sign_fix
//  Purely combinational sign handling around the unsigned iterative core.
//  Front end: decides per funct3 which operands are signed, produces operand
//  magnitudes and the result sign flags.  Back end: conditionally negates the
//  raw 2*XLEN product and the XLEN quotient/remainder.
// Ports
//  funct3_i      op code of the instruction being issued
//  rs1_i/rs2_i   raw operands
//  mag1_o/mag2_o operand magnitudes (unsigned operands pass through)
//  neg_ab_o      sign(rs1) xor sign(rs2): product and quotient sign
//  neg_a_o       sign(rs1): remainder sign
//  prod_i/prod_neg_i/prod_o  raw product, negate flag, signed product
//  quo_i/rem_i/quo_neg_i/rem_neg_i/quo_o/rem_o  same for the divider
// ----------------------------------------------------------------------------
module muldiv_sign_fix
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN = MD_XLEN
)
(
   input  logic [2:0]        funct3_i,
   input  logic [XLEN-1:0]   rs1_i,
   input  logic [XLEN-1:0]   rs2_i,
   output logic [XLEN-1:0]   mag1_o,
   output logic [XLEN-1:0]   mag2_o,
   output logic              neg_ab_o,
   output logic              neg_a_o,
   input  logic [2*XLEN-1:0] prod_i,
   input  logic              prod_neg_i,
   output logic [2*XLEN-1:0] prod_o,
   input  logic [XLEN-1:0]   quo_i,
   input  logic              quo_neg_i,
   output logic [XLEN-1:0]   quo_o,
   input  logic [XLEN-1:0]   rem_i,
   input  logic              rem_neg_i,
   output logic [XLEN-1:0]   rem_o
);

   logic rs1_signed;
   logic rs2_signed;
   logic sign1;
   logic sign2;

   always_comb begin
      // MUL is treated as unsigned: its low word is identical either way
      rs1_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                   (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
      rs2_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) ||
                   (funct3_i == F3_REM);
      sign1      = rs1_signed & rs1_i[XLEN-1];
      sign2      = rs2_signed & rs2_i[XLEN-1];
      // -2^(XLEN-1) maps onto itself, which is the correct unsigned magnitude
      mag1_o     = sign1 ? -rs1_i : rs1_i;
      mag2_o     = sign2 ? -rs2_i : rs2_i;
      neg_ab_o   = sign1 ^ sign2;
      neg_a_o    = sign1;

      prod_o     = prod_neg_i ? -prod_i : prod_i;
      quo_o      = quo_neg_i  ? -quo_i  : quo_i;
      rem_o      = rem_neg_i  ? -rem_i  : rem_i;
   end

endmodule : muldiv_sign_fix

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//  Iterative RV32M multiply/divide unit for the EX stage.  One shift-add
//  (multiply) or restoring shift-subtract (divide) step per cycle on operand
//  magnitudes; sign is restored on the last step.  The front of the pipeline
//  is held through stall while the unit iterates.
// Ports
//  clock, reset    rising-edge clock, asynchronous active-high reset
//  start, flush    op present in EX / kill of the EX instruction
//  funct3          RV32M op; rs1_val, rs2_val operands; rd_in destination
//  stall           hold PC, IF/ID and ID/EX this cycle
//  busy            FSM not idle
//  done            one-cycle pulse: result and rd_out valid
//  result, rd_out  last completed result and destination (held)
// ----------------------------------------------------------------------------
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN  = MD_XLEN,
   parameter int CNT_W = MD_CNT_W
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   md_state_e         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        op_lo_q;     // funct3[1:0] of the op in flight
   logic [4:0]        rd_q;
   logic [2*XLEN-1:0] acc_q;       // {hi, lo}: product or {remainder, quotient}
   logic [XLEN-1:0]   opd_q;       // multiplicand or divisor magnitude
   logic              neg_ab_q;
   logic              neg_a_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_out_q;
   logic              done_q;

   logic [XLEN-1:0]   mag1;
   logic [XLEN-1:0]   mag2;
   logic              neg_ab;
   logic              neg_a;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_acc_d;
   logic [XLEN:0]     rem_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_acc_d;
   logic [2*XLEN-1:0] step_acc_d;
   logic [XLEN-1:0]   final_res_d;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   short_res_d;

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .funct3_i   (funct3),
      .rs1_i      (rs1_val),
      .rs2_i      (rs2_val),
      .mag1_o     (mag1),
      .mag2_o     (mag2),
      .neg_ab_o   (neg_ab),
      .neg_a_o    (neg_a),
      .prod_i     (mul_acc_d),
      .prod_neg_i (neg_ab_q),
      .prod_o     (prod_fix),
      .quo_i      (div_acc_d[XLEN-1:0]),
      .quo_neg_i  (neg_ab_q),
      .quo_o      (quo_fix),
      .rem_i      (div_acc_d[2*XLEN-1:XLEN]),
      .rem_neg_i  (neg_a_q),
      .rem_o      (rem_fix)
   );

   always_comb begin
      // multiply step: add multiplicand into the high half when the current
      // multiplier bit (acc lsb) is set, then shift the whole accumulator right
      mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
      mul_acc_d  = {mul_sum, acc_q[XLEN-1:1]};

      // divide step: shift the next dividend bit into the partial remainder,
      // keep the difference only if it did not go negative
      rem_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff   = rem_shift - {1'b0, opd_q};
      if (div_diff[XLEN]) begin
         div_acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         div_acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end

      step_acc_d = (state_q == ST_DIV) ? div_acc_d : mul_acc_d;

      if (state_q == ST_DIV) begin
         final_res_d = op_lo_q[1] ? rem_fix : quo_fix;
      end else begin
         final_res_d = (op_lo_q == 2'b00) ? prod_fix[XLEN-1:0]
                                          : prod_fix[2*XLEN-1:XLEN];
      end

      // divide cases resolved without iterating
      div_zero   = (rs2_val == '0);
      div_ovf    = ~funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (rs2_val == '1);
      if (div_zero) begin
         short_res_d = funct3[1] ? rs1_val : '1;
      end else begin
         short_res_d = funct3[1] ? '0 : rs1_val;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_lo_q  <= '0;
         rd_q     <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         neg_ab_q <= 1'b0;
         neg_a_q  <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            // killed op: no done, result/rd_out keep their last values
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     op_lo_q  <= funct3[1:0];
                     rd_q     <= rd_in;
                     neg_ab_q <= neg_ab;
                     neg_a_q  <= neg_a;
                     cnt_q    <= CNT_W'(XLEN);
                     opd_q    <= funct3[2] ? mag2 : mag1;
                     acc_q    <= {{XLEN{1'b0}}, (funct3[2] ? mag1 : mag2)};
                     if (funct3[2] && (div_zero || div_ovf)) begin
                        cnt_q    <= '0;
                        result_q <= short_res_d;
                        rd_out_q <= rd_in;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                     end else begin
                        state_q  <= funct3[2] ? ST_DIV : ST_MUL;
                     end
                  end
               end
               ST_MUL, ST_DIV: begin
                  acc_q <= step_acc_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     result_q <= final_res_d;
                     rd_out_q <= rd_q;
                     done_q   <= 1'b1;
                     state_q  <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  // a start seen here is picked up from IDLE on the next edge
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // stall is combinational on start so the issuing instruction never leaves ID/EX
   assign stall  = ((state_q == ST_IDLE) && start && !flush) ||
                   (state_q == ST_MUL) || (state_q == ST_DIV);
   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign result = result_q;
   assign rd_out = rd_out_q;

endmodule : ex_muldiv_unit
